// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one load/store request into one or two word-bus accesses
// and merges split load data. Optional macro LSU_MISALIGN_TRAP_EN traps split accesses instead.
module load_store_unit #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [ALEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misaligned,
    output logic            mem_write,
    output logic [3:0]      mem_be,
    output logic [2:0]      mem_funct3,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, RESP} state_t;

    state_t          state_q;
    logic            wr_q, split_q, resp_valid_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [3:0]      be_hi_q;
    logic [ALEN-1:0] addr_hi_q;
    logic [XLEN-1:0] wdata_hi_q, lo_word_q;
    logic            mem_write_q;
    logic [3:0]      mem_be_q;
    logic [2:0]      mem_funct3_q;
    logic [ALEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

    logic            in_split;
    logic [3:0]      in_mask;
    logic [7:0]      in_lanes;
    logic [1:0]      in_neg_off;
    logic [ALEN-3:0] in_word_nxt;
    logic [XLEN-1:0] split_word, split_val;

    assign in_mask     = (req_funct3[1:0] == 2'b00) ? 4'b0001 :
                         (req_funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign in_split    = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Low nibble drives the first access, high nibble spills into the next word.
    assign in_lanes    = {4'b0000, in_mask} << req_addr[1:0];
    assign in_neg_off  = 2'd0 - req_addr[1:0];
    assign in_word_nxt = req_addr[ALEN-1:2] + (ALEN-2)'(1);

    // Second word arrives in RESP; first word was latched during ISSUE1.
    assign split_word = XLEN'({mem_rdata, lo_word_q} >> {off_q, 3'b000});
    assign split_val  = (f3_q[1:0] == 2'b10) ? split_word :
                        f3_q[2] ? {{(XLEN-16){1'b0}}, split_word[15:0]} :
                                  {{(XLEN-16){split_word[15]}}, split_word[15:0]};

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign resp_misaligned = mis_q;
`else
    assign resp_misaligned = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = (resp_valid_q && !wr_q && !resp_misaligned) ?
                        (split_q ? split_val : mem_rdata) : '0;
    assign mem_write  = mem_write_q;
    assign mem_be     = mem_be_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            split_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            be_hi_q      <= '0;
            addr_hi_q    <= '0;
            wdata_hi_q   <= '0;
            lo_word_q    <= '0;
            mem_write_q  <= 1'b0;
            mem_be_q     <= '0;
            mem_funct3_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        f3_q       <= req_funct3;
                        off_q      <= req_addr[1:0];
                        split_q    <= in_split;
                        be_hi_q    <= in_lanes[7:4];
                        addr_hi_q  <= {in_word_nxt, 2'b00};
                        wdata_hi_q <= req_wdata >> {in_neg_off, 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
                        if (in_split) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            mis_q        <= 1'b1;
                        end else
`endif
                        begin
                            state_q      <= ISSUE0;
                            mem_write_q  <= req_write;
                            mem_be_q     <= req_write ? in_lanes[3:0] : 4'b0000;
                            mem_addr_q   <= req_addr;
                            mem_wdata_q  <= req_wdata;
                            mem_funct3_q <= in_split ? 3'b010 : req_funct3;
                        end
                    end
                end
                ISSUE0: begin
                    if (split_q) begin
                        state_q      <= ISSUE1;
                        mem_addr_q   <= addr_hi_q;
                        mem_be_q     <= be_hi_q;
                        mem_wdata_q  <= wdata_hi_q;
                        mem_funct3_q <= 3'b010;
                    end else begin
                        state_q      <= RESP;
                        mem_write_q  <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        resp_valid_q <= 1'b1;
                    end
                end
                ISSUE1: begin
                    lo_word_q    <= mem_rdata;
                    state_q      <= RESP;
                    mem_write_q  <= 1'b0;
                    mem_be_q     <= 4'b0000;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q        <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-array reference memory, word-bus memory model,
// directed cases for alignment, splitting, wrap and mid-access reset.
module tb_load_store_unit;
    logic        clk, rst_n, req_valid, req_ready, req_write;
    logic [2:0]  req_funct3, mem_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        resp_valid, resp_misaligned, mem_write;
    logic [3:0]  mem_be;

    int n_chk = 0, n_err = 0;

    logic [31:0] bmem [1024];
    bit          wr_flag [1024];
    logic [7:0]  rmem [4096];

    logic [31:0] s_addr [1:8], s_wd [1:8];
    logic [3:0]  s_be [1:8];
    logic [2:0]  s_f3 [1:8];
    logic        s_wr [1:8];
    int          last_lat;
    logic [31:0] last_rd;
    logic        last_mis;

    load_store_unit #(.XLEN(32), .ALEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_write(mem_write), .mem_be(mem_be), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [31:0] cur_word(input int i);
        return wr_flag[i] ? bmem[i] : init_word(i);
    endfunction

    function automatic logic [31:0] merge_w(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be, input logic [1:0] off);
        logic [31:0] sh, w;
        sh = wd << (8 * off);
        w  = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = sh[8*i +: 8];
        return w;
    endfunction

    // Word-bus memory: formats aligned sub-word reads, returns the raw word for funct3=010.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_write) begin
            bmem[mem_addr[11:2]]    <= merge_w(cur_word(int'(mem_addr[11:2])), mem_wdata, mem_be, mem_addr[1:0]);
            wr_flag[mem_addr[11:2]] <= 1'b1;
        end
        mem_rdata <= fmt(cur_word(int'(mem_addr[11:2])), mem_funct3, mem_addr[1:0]);
    end

    function automatic int nb(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        logic [11:0] ix;
        int n;
        n = nb(f3);
        v = '0;
        for (int i = 0; i < n; i++) begin
            ix = 12'(a + 32'(i));
            v[8*i +: 8] = rmem[ix];
        end
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [11:0] ix;
        for (int i = 0; i < nb(f3); i++) begin
            ix = 12'(a + 32'(i));
            rmem[ix] = wd[8*i +: 8];
        end
    endtask

    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n, exp_lat;
        logic crosses, trap;
        logic [31:0] exp_rd;
        n = nb(f3);
        crosses = ((a & 32'd3) + 32'(n)) > 32'd4;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = crosses;
`else
        trap = 1'b0;
`endif
        exp_lat = trap ? 1 : crosses ? 3 : 2;
        exp_rd  = (w || trap) ? 32'h0 : ref_load(a, f3);
        @(negedge clk);
        chk("ready", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        last_lat = 0;
        for (int k = 1; k <= 8 && last_lat == 0; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            s_wr[k] = mem_write; s_be[k] = mem_be; s_f3[k] = mem_funct3;
            s_addr[k] = mem_addr; s_wd[k] = mem_wdata;
            if (resp_valid) begin
                last_lat = k; last_rd = resp_rdata; last_mis = resp_misaligned;
                req_valid = 1'b0;
                chk("resp_wr", mem_write, 0);
                chk("resp_be", mem_be, 0);
            end else begin
                // Busy: garbage on the request port must be ignored.
                req_valid = 1'($urandom); req_write = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        chk("latency", last_lat, exp_lat);
        if (last_lat != 0) begin
            chk("rdata", last_rd, exp_rd);
            chk("misaligned", last_mis, trap);
        end
        @(posedge clk); #1;
        chk("pulse", resp_valid, 0);
        if (w && !trap) ref_store(a, f3, wd);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < 1024; i++)
            for (int b = 0; b < 4; b++) rmem[4*i + b] = 8'(init_word(i) >> (8*b));
        req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_mis", resp_misaligned, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_f3", mem_funct3, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run(1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_wr", s_wr[1], 1); chk("sw_be", s_be[1], 4'hF);
        chk("sw_f3", s_f3[1], 3'b010); chk("sw_addr", s_addr[1], 32'h100);
        chk("sw_lat", last_lat, 2); chk("sw_rd", last_rd, 0);

        run(1, 3'b000, 32'h103, 32'h000000A5);
        chk("sb_be", s_be[1], 4'b1000); chk("sb_wd", s_wd[1], 32'hA5); chk("sb_lat", last_lat, 2);

        run(1, 3'b010, 32'h100, 32'h80011234);
        run(0, 3'b001, 32'h102, 32'h0);
        chk("lh_f3", s_f3[1], 3'b001); chk("lh_be", s_be[1], 4'b0000);
        chk("lh_rd", last_rd, 32'hFFFF8001); chk("lh_lat", last_lat, 2);

        run(1, 3'b010, 32'h100, 32'h44332211);
        run(1, 3'b010, 32'h104, 32'h88776655);
        run(0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_split_lat", last_lat, 1); chk("lw_split_mis", last_mis, 1); chk("lw_split_rd", last_rd, 0);
`else
        chk("lw_split_a0", s_addr[1], 32'h101); chk("lw_split_a1", s_addr[2], 32'h104);
        chk("lw_split_f0", s_f3[1], 3'b010); chk("lw_split_f1", s_f3[2], 3'b010);
        chk("lw_split_lat", last_lat, 3); chk("lw_split_rd", last_rd, 32'h55443322);
        run(0, 3'b101, 32'h103, 32'h0);
        chk("lhu_split_rd", last_rd, 32'h00005544); chk("lhu_split_lat", last_lat, 3);
`endif

        run(1, 3'b010, 32'h103, 32'hAABBCCDD);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sw_split_nowr", s_wr[1], 0); chk("sw_split_mis", last_mis, 1); chk("sw_split_lat", last_lat, 1);
`else
        chk("sw_split_be0", s_be[1], 4'b1000); chk("sw_split_wd0", s_wd[1], 32'hAABBCCDD);
        chk("sw_split_a1", s_addr[2], 32'h104); chk("sw_split_be1", s_be[2], 4'b0111);
        chk("sw_split_wd1", s_wd[2], 32'h00AABBCC);
        run(0, 3'b010, 32'h104, 32'h0); chk("sw_split_hi", last_rd, 32'h88AABBCC);
        run(0, 3'b100, 32'h103, 32'h0); chk("sw_split_lo", last_rd, 32'h000000DD);
`endif

        run(0, 3'b010, 32'h80000000, 32'h0);
        chk("mmio_addr", s_addr[1], 32'h80000000); chk("mmio_f3", s_f3[1], 3'b010); chk("mmio_lat", last_lat, 2);
`ifndef LSU_MISALIGN_TRAP_EN
        run(0, 3'b001, 32'hFFFFFFFF, 32'h0);
        chk("wrap_a1", s_addr[2], 32'h0);
`endif

        // Reset in the middle of an access.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h55667788;
`ifdef LSU_MISALIGN_TRAP_EN
        req_addr = 32'h100;
        @(posedge clk); #1 req_valid = 1'b0;
`else
        req_addr = 32'h103;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        rmem[12'h103] = 8'h88;
`endif
        chk("rst_pre_wr", mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", mem_write, 0); chk("rst_mid_be", mem_be, 0);
        chk("rst_mid_resp", resp_valid, 0); chk("rst_mid_ready", req_ready, 1);
        repeat (2) begin @(posedge clk); #1 chk("rst_hold_resp", resp_valid, 0); end
        @(negedge clk) rst_n = 1'b1;
        run(0, 3'b010, 32'h100, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("rst_after_lo", last_rd, 32'h88332211);
        run(0, 3'b010, 32'h104, 32'h0);
        chk("rst_after_hi", last_rd, 32'h88AABBCC);
`endif

        for (int t = 0; t < 300; t++) begin
            w = 1'($urandom);
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = w ? 3'b000 : 3'b100;
                default: f3 = w ? 3'b001 : 3'b101;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
                1: a = 32'h80000000 | (a & 32'hFFF);
                default: ;
            endcase
            run(w, f3, a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory port. It sits between the CPU MEM stage and the data memory, and converts one load/store request into one or two word-bus accesses: byte enables, address, funct3 and write data. It splits accesses that cross a word boundary. It collects the memory's 1-cycle-latency read data and merges, sign-extends or zero-extends it. It returns a single-cycle response pulse to the pipeline.

Parameters:
XLEN, 32, data width (riscv_pkg value)
ALEN, 32, address width (riscv_pkg value)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when both high
req_write  input  1  1=store, 0=load
req_funct3  input  3  LB/LH/LW/LBU/LHU/SB/SH/SW encoding
req_addr  input  ALEN  byte address
req_wdata  input  XLEN  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  XLEN  load result, extended; 0 for stores
resp_misaligned  output  1  misaligned trap flag (see Optional Feature)
mem_write  output  1  memory write strobe
mem_be  output  4  byte enables, lane-relative
mem_funct3  output  3  access type presented to memory
mem_addr  output  ALEN  byte address presented to memory
mem_wdata  output  XLEN  unshifted write data (memory shifts by addr[1:0]*8)
mem_rdata  input  XLEN  memory read data, valid the cycle after the address is presented

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_misaligned=0; mem_write=0, mem_be=0, mem_addr=0, mem_wdata=0, mem_funct3=0.
  - An in-flight request is discarded.
  - No write strobe is asserted after reset, even mid-split.
- Request capture: registered on the accept edge. req_ready=1 only in IDLE. Inputs are ignored while busy.
- Split condition, with off = addr[1:0]:
  - (funct3[1:0]==01 and off==3), or (funct3[1:0]==10 and off!=0).
- States: IDLE -> ISSUE0 -> (split ? ISSUE1 : RESP) -> RESP -> IDLE.
- Mask: 0001 for byte, 0011 for half, 1111 for word.
- ISSUE0:
  - mem_addr = req_addr; mem_write = req_write.
  - mem_be = (mask << off)[3:0] for stores, 0 for loads.
  - mem_wdata = req_wdata.
  - mem_funct3 = req_funct3 if not split; 010 if split.
- ISSUE1 (split only):
  - mem_addr = {req_addr[ALEN-1:2]+1, 2'b00}; wraps 0xFFFFFFFC -> 0x00000000.
  - mem_be = (mask << off) >> 4.
  - mem_wdata = req_wdata >> ((4-off)*8).
  - mem_funct3 = 010.
  - mem_rdata (word 0) is latched into lo_word this cycle.
- RESP: resp_valid=1 for exactly one cycle. Load results:
  - Not split: resp_rdata = mem_rdata; the memory has already formatted it.
  - Split: resp_rdata = low 16/32 bits of ({mem_rdata, lo_word} >> off*8). Halfwords are sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1.
- Outside ISSUE0/ISSUE1: mem_write=0 and mem_be=0.
- Latency from accept edge: aligned resp_valid at T+2; split at T+3. Back-to-back requests are accepted the cycle after RESP.
- No response backpressure; the consumer must sample on the resp_valid pulse.
- MMIO addresses (0x80000000, 0x80001000) get no special treatment; aligned accesses pass through unchanged.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a split-condition request performs no memory access. The FSM goes IDLE -> RESP, so resp_valid fires at T+1 with resp_misaligned=1 and resp_rdata=0.
- Undefined: split accesses execute as above, and resp_misaligned is tied 0.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF -> at T+1 mem_write=1, be=1111, funct3=010, addr=0x100; resp_valid at T+2, resp_rdata=0.
2. SB addr 0x103, wdata 0x000000A5 -> single access, be=1000, mem_wdata=0x000000A5; no ISSUE1.
3. LH addr 0x102, memory word 0x8001_1234 -> mem_funct3=001, mem_be=0000; resp_rdata=0xFFFF8001 at T+2.
4. LW addr 0x101, words [0x100]=0x44332211, [0x104]=0x88776655 -> accesses to 0x101 then 0x104, both funct3=010; resp_rdata=0x55443322 at T+3. Repeat as LHU at 0x103 -> 0x00005544.
5. SW addr 0x103, wdata 0xAABBCCDD -> access0 be=1000, wdata 0xAABBCCDD; access1 addr 0x104, be=0111, wdata 0x00AABBCC; memory then reads 0xDD at 0x103 and 0xAABBCC at 0x104-0x106. With LSU_MISALIGN_TRAP_EN defined -> no mem_write, resp_misaligned=1 at T+1.
6. rst_n pulsed low during ISSUE1 of case 5 -> mem_write drops immediately, no resp_valid; req_ready=1 after release, and the next aligned request completes normally.
